// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl : instruction fetch sequencer
//
// Each cycle the current PC is looked up in a direct-mapped icache. A hit is
// delivered into the output register. A miss fetches the four bytes of the
// word (little-endian, addresses pc..pc+3) through the byte-wide memory
// arbiter port, writes the assembled word into the icache, and then retries
// the lookup. A flush redirects the PC and discards any in-flight work.
//
// Handshakes:
//   * Output: a word transfers on a rising edge where instr_valid_out and
//     instr_ready_in are both 1 (and rdy_in is 1). instr_valid_out/instr_out
//     /pc_out are registered and hold while not accepted.
//   * Memory: mem_req and mem_addr are held stable until mem_ack; the byte on
//     mem_data_in is taken in the same cycle as mem_ack.
//   * rdy_in=0 freezes every register; mem_ack is ignored in that cycle.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global stall)
//   flush_in/flush_pc_in        redirect request and target
//   ic_req_valid/ic_pc_request  icache lookup; ic_hit_in/ic_instr_in same cycle
//   ic_wr_valid/ic_pc_update/ic_instr_update  icache fill
//   mem_req/mem_addr/mem_ack/mem_data_in      byte read port
//   instr_valid_out/instr_out/pc_out/instr_ready_in  output to decode
//   state_dbg                   current FSM state for observation
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in,
    output logic        ic_req_valid,
    output logic [31:0] ic_pc_request,
    input  logic        ic_hit_in,
    input  logic [31:0] ic_instr_in,
    output logic        ic_wr_valid,
    output logic [31:0] ic_pc_update,
    output logic [31:0] ic_instr_update,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data_in,
    output logic        instr_valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    input  logic        instr_ready_in,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_LOOKUP = 2'd0,
        S_MISS   = 2'd1,
        S_FILL   = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [1:0]  cnt;
    logic [31:0] fill_buf;
    logic        out_free;

    // The output register can take a new word if it is empty or being drained.
    assign out_free = !instr_valid_out || instr_ready_in;

    // Strobes are decoded from state; gating with rst_in keeps them low while
    // reset is held, even though the reset state is LOOKUP.
    assign ic_req_valid    = rst_in && (state == S_LOOKUP) && out_free;
    assign ic_pc_request   = pc;
    assign mem_req         = rst_in && (state == S_MISS);
    assign mem_addr        = pc + {30'd0, cnt};
    assign ic_wr_valid     = rst_in && (state == S_FILL);
    assign ic_pc_update    = pc;
    assign ic_instr_update = fill_buf;
    assign state_dbg       = state;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= S_LOOKUP;
            pc              <= RESET_PC;
            cnt             <= 2'd0;
            fill_buf        <= 32'd0;
            instr_valid_out <= 1'b0;
            instr_out       <= 32'd0;
            pc_out          <= 32'd0;
        end else if (rdy_in) begin
            if (flush_in) begin
                // Redirect wins over everything. A FILL in progress still
                // writes this cycle through the combinational strobe, and a
                // same-cycle mem_ack or icache hit is simply dropped.
                pc              <= flush_pc_in;
                cnt             <= 2'd0;
                instr_valid_out <= 1'b0;
                state           <= S_LOOKUP;
            end else begin
                if (instr_valid_out && instr_ready_in) begin
                    instr_valid_out <= 1'b0;
                end
                case (state)
                    S_LOOKUP: begin
                        if (out_free) begin
                            if (ic_hit_in) begin
                                // Overrides the consume-clear above.
                                instr_valid_out <= 1'b1;
                                instr_out       <= ic_instr_in;
                                pc_out          <= pc;
                                pc              <= pc + 32'd4;
                            end else begin
                                state <= S_MISS;
                                cnt   <= 2'd0;
                            end
                        end
                    end
                    S_MISS: begin
                        if (mem_ack) begin
                            fill_buf[{cnt, 3'b000} +: 8] <= mem_data_in;
                            cnt <= cnt + 2'd1;
                            if (cnt == 2'd3) begin
                                state <= S_FILL;
                            end
                        end
                    end
                    S_FILL: begin
                        state <= S_LOOKUP;
                    end
                    default: begin
                        state <= S_LOOKUP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl : self-checking bench for fetch_ctrl
//
// The bench plays both the icache (small direct-mapped tag/data arrays) and
// the memory (a fixed byte function). A reference model tracks the fetch in
// terms of "next PC", "is a miss outstanding" and "how many bytes collected",
// and predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0;

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic [31:0] flush_pc_in;
    logic        ic_req_valid;
    logic [31:0] ic_pc_request;
    logic        ic_hit_in;
    logic [31:0] ic_instr_in;
    logic        ic_wr_valid;
    logic [31:0] ic_pc_update;
    logic [31:0] ic_instr_update;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data_in;
    logic        instr_valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_ready_in;
    logic [1:0]  state_dbg;
    logic        ack_en;

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .flush_in        (flush_in),
        .flush_pc_in     (flush_pc_in),
        .ic_req_valid    (ic_req_valid),
        .ic_pc_request   (ic_pc_request),
        .ic_hit_in       (ic_hit_in),
        .ic_instr_in     (ic_instr_in),
        .ic_wr_valid     (ic_wr_valid),
        .ic_pc_update    (ic_pc_update),
        .ic_instr_update (ic_instr_update),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_data_in     (mem_data_in),
        .instr_valid_out (instr_valid_out),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .instr_ready_in  (instr_ready_in),
        .state_dbg       (state_dbg)
    );

    // ---------------- memory and icache responders ----------------
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h00;
            32'd3:   return 8'h00;
            default: return (a[7:0] * 8'd7) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    logic        c_val[64];
    logic [31:0] c_tag[64];
    logic [31:0] c_dat[64];

    assign mem_ack     = ack_en && mem_req;
    assign mem_data_in = mem_byte(mem_addr);
    assign ic_hit_in   = c_val[ic_pc_request[7:2]] && (c_tag[ic_pc_request[7:2]] == ic_pc_request);
    assign ic_instr_in = c_dat[ic_pc_request[7:2]];

    task automatic prefill(input logic [31:0] a);
        c_val[a[7:2]] = 1'b1;
        c_tag[a[7:2]] = a;
        c_dat[a[7:2]] = mem_word(a);
    endtask

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcout;
    logic        m_valid;
    logic        m_missing;
    int          m_got;

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_instr   = 32'd0;
        m_pcout   = 32'd0;
        m_valid   = 1'b0;
        m_missing = 1'b0;
        m_got     = 0;
    endtask

    // One clock: compare current outputs, advance the model, cross the edge.
    // Must be entered in the clock-low phase with inputs already driven.
    task automatic tick();
        logic        free, e_req, e_mreq, e_wr, hit;
        logic        wr_now;
        logic [31:0] wr_pc, wr_dat, e;
        #1;
        free   = !m_valid || instr_ready_in;
        e_req  = !m_missing && free;
        e_mreq = m_missing && (m_got < 4);
        e_wr   = m_missing && (m_got == 4);

        chk("ic_req_valid", {31'd0, ic_req_valid}, {31'd0, e_req});
        if (e_req) chk("ic_pc_request", ic_pc_request, m_pc);
        chk("mem_req", {31'd0, mem_req}, {31'd0, e_mreq});
        if (e_mreq) chk("mem_addr", mem_addr, m_pc + 32'(m_got));
        chk("ic_wr_valid", {31'd0, ic_wr_valid}, {31'd0, e_wr});
        if (e_wr) begin
            chk("ic_pc_update", ic_pc_update, m_pc);
            chk("ic_instr_update", ic_instr_update, mem_word(m_pc));
        end
        chk("instr_valid_out", {31'd0, instr_valid_out}, {31'd0, m_valid});
        if (m_valid) begin
            chk("instr_out", instr_out, m_instr);
            chk("pc_out", pc_out, m_pcout);
        end
        if (rdy_in && instr_valid_out && instr_ready_in && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stream_pc", pc_out, e);
        end

        hit    = c_val[m_pc[7:2]] && (c_tag[m_pc[7:2]] == m_pc);
        wr_now = ic_wr_valid;
        wr_pc  = ic_pc_update;
        wr_dat = ic_instr_update;

        if (rdy_in) begin
            if (flush_in) begin
                m_pc      = flush_pc_in;
                m_valid   = 1'b0;
                m_missing = 1'b0;
                m_got     = 0;
            end else begin
                if (m_valid && instr_ready_in) m_valid = 1'b0;
                if (!m_missing) begin
                    if (free) begin
                        if (hit) begin
                            m_valid = 1'b1;
                            m_instr = mem_word(m_pc);
                            m_pcout = m_pc;
                            m_pc    = m_pc + 32'd4;
                        end else begin
                            m_missing = 1'b1;
                            m_got     = 0;
                        end
                    end
                end else if (m_got < 4) begin
                    if (ack_en) m_got++;
                end else begin
                    m_missing = 1'b0;
                end
            end
        end

        @(posedge clk_in);
        @(negedge clk_in);
        if (wr_now) begin
            c_val[wr_pc[7:2]] = 1'b1;
            c_tag[wr_pc[7:2]] = wr_pc;
            c_dat[wr_pc[7:2]] = wr_dat;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic saw_fill;
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; flush_pc_in = 32'd0;
        instr_ready_in = 1'b0; ack_en = 1'b0;
        for (int i = 0; i < 64; i++) begin
            c_val[i] = 1'b0; c_tag[i] = 32'd0; c_dat[i] = 32'd0;
        end
        model_reset();

        // Reset state
        repeat (3) @(negedge clk_in);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_ic_wr_valid", {31'd0, ic_wr_valid}, 32'd0);
        chk("rst_ic_req_valid", {31'd0, ic_req_valid}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid_out}, 32'd0);
        chk("rst_instr_out", instr_out, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        rst_in = 1'b1;
        #1;
        chk("first_lookup_pc", ic_pc_request, RESET_PC);

        // Cold miss at 0: one ack per cycle, word visible 7 cycles after lookup
        ack_en = 1'b1;
        for (int i = 0; i <= 7; i++) begin
            if (i == 5) begin
                chk("cold_fill_strobe", {31'd0, ic_wr_valid}, 32'd1);
                chk("cold_fill_word", ic_instr_update, 32'h0000_0513);
                chk("cold_fill_pc", ic_pc_update, 32'h0);
            end
            if (i == 6) chk("cold_not_yet_valid", {31'd0, instr_valid_out}, 32'd0);
            if (i == 7) begin
                chk("cold_valid", {31'd0, instr_valid_out}, 32'd1);
                chk("cold_instr", instr_out, 32'h0000_0513);
                chk("cold_pc", pc_out, 32'h0);
                instr_ready_in = 1'b1;
            end
            tick();
        end

        // Hit streaming from prefilled 0x100..0x10C
        for (int k = 0; k < 4; k++) prefill(32'h100 + 32'(4 * k));
        flush_in = 1'b1; flush_pc_in = 32'h100;
        tick();
        flush_in = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) exp_q.push_back(32'h100 + 32'(4 * k));
        for (int k = 0; k < 4; k++) begin
            chk("stream_valid", {31'd0, instr_valid_out}, 32'd1);
            chk("stream_pc_lit", pc_out, 32'h100 + 32'(4 * k));
            tick();
        end
        chk("stream_q_left", exp_q.size(), 32'd0);

        // Backpressure for 3 cycles after a hit
        instr_ready_in = 1'b0;
        flush_in = 1'b1; flush_pc_in = 32'h100;
        tick();
        flush_in = 1'b0;
        tick();
        for (int j = 0; j < 3; j++) begin
            chk("bp_pc_out", pc_out, 32'h100);
            chk("bp_instr_out", instr_out, mem_word(32'h100));
            chk("bp_no_lookup", {31'd0, ic_req_valid}, 32'd0);
            chk("bp_pc_held", ic_pc_request, 32'h104);
            tick();
        end
        for (int k = 0; k < 4; k++) exp_q.push_back(32'h100 + 32'(4 * k));
        instr_ready_in = 1'b1;
        repeat (5) tick();
        chk("bp_q_left", exp_q.size(), 32'd0);

        // Slow arbiter: acks every third cycle
        flush_in = 1'b1; flush_pc_in = 32'h300;
        tick();
        flush_in = 1'b0;
        saw_fill = 1'b0;
        for (int n = 0; n < 20; n++) begin
            ack_en = (n % 3 == 2);
            if (ic_wr_valid && !saw_fill) begin
                saw_fill = 1'b1;
                chk("slow_fill_word", ic_instr_update, mem_word(32'h300));
            end
            tick();
        end
        chk("slow_fill_seen", {31'd0, saw_fill}, 32'd1);

        // Flush mid-miss after 2 bytes, ack in the flush cycle
        ack_en = 1'b1;
        flush_in = 1'b1; flush_pc_in = 32'h400;
        tick();
        flush_in = 1'b0;
        repeat (3) tick();
        chk("mid_miss_addr", mem_addr, 32'h402);
        flush_in = 1'b1; flush_pc_in = 32'h200;
        tick();
        flush_in = 1'b0;
        #1;
        chk("flush_mem_req_drop", {31'd0, mem_req}, 32'd0);
        chk("flush_no_fill", {31'd0, ic_wr_valid}, 32'd0);
        chk("flush_new_pc", ic_pc_request, 32'h200);
        tick();
        chk("refetch_byte0", mem_addr, 32'h200);
        repeat (8) tick();

        // PC and byte-address wrap
        flush_in = 1'b1; flush_pc_in = 32'hFFFF_FFFC;
        tick();
        flush_in = 1'b0;
        repeat (12) tick();
        flush_in = 1'b1; flush_pc_in = 32'hFFFF_FFFE;
        tick();
        flush_in = 1'b0;
        repeat (12) tick();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rdy_in         = ($urandom_range(0, 9) != 0);
            flush_in       = ($urandom_range(0, 29) == 0);
            flush_pc_in    = ($urandom_range(0, 3) == 0) ? $urandom
                                                         : {23'd0, 7'($urandom_range(0, 127)), 2'b00};
            instr_ready_in = ($urandom_range(0, 9) < 7);
            ack_en         = ($urandom_range(0, 9) < 6);
            tick();
        end

        // Asynchronous reset in the middle of a miss
        rdy_in = 1'b1; instr_ready_in = 1'b1; ack_en = 1'b0;
        flush_in = 1'b1; flush_pc_in = 32'h500;
        tick();
        flush_in = 1'b0;
        repeat (2) tick();
        chk("pre_rst_in_miss", {31'd0, mem_req}, 32'd1);
        #2;
        rst_in = 1'b0;
        #1;
        chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("async_rst_valid", {31'd0, instr_valid_out}, 32'd0);
        chk("async_rst_ic_req", {31'd0, ic_req_valid}, 32'd0);
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("post_rst_pc", ic_pc_request, RESET_PC);
        ack_en = 1'b1;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
